// File: rtl/memory_responder.sv
// memory_responder: RAM plus peripheral window answering the core's read and masked-write ports.
// Define MEMORY_RESPONDER_MMIO_EN to decode the console / cycle counter / halt window.
module memory_responder #(
    parameter int          DEPTH_WORDS   = 4096,
    parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
    parameter int          CONSOLE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_memory_address,
    output logic [31:0] read_memory_data,
    input  logic [31:0] write_memory_address,
    input  logic [31:0] write_memory_data,
    input  logic [31:0] write_memory_mask,
    input  logic        memory_write_enable,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic          r_fault;
    logic          w_rd_ram;
    logic          w_wr_ram;
    logic          w_rd_mmio;
    logic          w_wr_mmio;
    logic          w_wr;
    logic [AW-1:0] w_ridx;
    logic [AW-1:0] w_widx;
    logic [31:0]   w_mmio_rdata;

    assign w_wr     = memory_write_enable;
    assign w_rd_ram = {1'b0, read_memory_address} < RAM_BYTES;
    assign w_wr_ram = {1'b0, write_memory_address} < RAM_BYTES;
    assign w_ridx   = read_memory_address[AW+1:2];
    assign w_widx   = write_memory_address[AW+1:2];

    always_ff @(posedge clk) begin
        if (w_wr && w_wr_ram)
            r_mem[w_widx] <= (r_mem[w_widx] & ~write_memory_mask) | (write_memory_data & write_memory_mask);
    end

    // RAM read sees the pre-write word on a same-cycle collision (read-first)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= 32'h0;
            r_fault <= 1'b0;
        end else begin
            r_rdata <= w_rd_ram ? r_mem[w_ridx] : w_rd_mmio ? w_mmio_rdata : 32'h0;
            r_fault <= r_fault | !(w_rd_ram || w_rd_mmio) | (w_wr && !(w_wr_ram || w_wr_mmio));
        end
    end

    assign read_memory_data = r_rdata;
    assign fault            = r_fault;

`ifdef MEMORY_RESPONDER_MMIO_EN
    localparam int CW = $clog2(CONSOLE_DEPTH);
    localparam logic [CW:0] FULL_N = (CW+1)'(CONSOLE_DEPTH);

    logic [7:0]    r_fifo [CONSOLE_DEPTH];
    logic [CW-1:0] r_head;
    logic [CW-1:0] r_tail;
    logic [CW:0]   r_count;
    logic [63:0]   r_cycle;
    logic [31:0]   r_shadow;
    logic [31:0]   r_ovf;
    logic          r_halt;
    logic [31:0]   r_halt_code;
    logic [9:0]    w_roff;
    logic [9:0]    w_woff;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_acc;

    assign w_rd_mmio = read_memory_address[31:12] == MMIO_BASE[31:12];
    assign w_wr_mmio = write_memory_address[31:12] == MMIO_BASE[31:12];
    assign w_roff    = read_memory_address[11:2];
    assign w_woff    = write_memory_address[11:2];
    assign w_full    = r_count == FULL_N;
    assign w_empty   = r_count == '0;
    assign w_pop     = !w_empty && console_ready;
    assign w_push    = w_wr && w_wr_mmio && w_woff == 10'h000 && |write_memory_mask[7:0];
    // a pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign w_acc     = w_push && (!w_full || w_pop);

    assign w_mmio_rdata = w_roff == 10'h001 ? {30'(r_count), w_full, w_empty} :
                          w_roff == 10'h002 ? r_cycle[31:0] :
                          w_roff == 10'h003 ? r_shadow :
                          w_roff == 10'h005 ? r_ovf : 32'h0;

    always_ff @(posedge clk) begin
        if (w_acc)
            r_fifo[r_tail] <= write_memory_data[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_cycle     <= 64'h0;
            r_shadow    <= 32'h0;
            r_ovf       <= 32'h0;
            r_halt      <= 1'b0;
            r_halt_code <= 32'h0;
        end else begin
            r_head  <= r_head + CW'(w_pop);
            r_tail  <= r_tail + CW'(w_acc);
            r_count <= r_count + (CW+1)'(w_acc) - (CW+1)'(w_pop);
            r_cycle <= r_cycle + 64'd1;
            if (w_rd_mmio && w_roff == 10'h002)
                r_shadow <= r_cycle[63:32];
            if (w_push && w_full && !w_pop && r_ovf != 32'hFFFF_FFFF)
                r_ovf <= r_ovf + 32'd1;
            if (w_wr && w_wr_mmio && w_woff == 10'h004 && !r_halt) begin
                r_halt      <= 1'b1;
                r_halt_code <= write_memory_data & write_memory_mask;
            end
        end
    end

    assign console_valid = !w_empty;
    assign console_data  = w_empty ? 8'h00 : r_fifo[r_head];
    assign halt          = r_halt;
    assign halt_code     = r_halt_code;
`else
    logic w_unused;

    assign w_rd_mmio     = 1'b0;
    assign w_wr_mmio     = 1'b0;
    assign w_mmio_rdata  = 32'h0;
    assign console_valid = 1'b0;
    assign console_data  = 8'h00;
    assign halt          = 1'b0;
    assign halt_code     = 32'h0;
    assign w_unused      = console_ready ^ (CONSOLE_DEPTH == 0) ^ (MMIO_BASE == 32'h0);
`endif
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: table-driven RAM vectors plus hand sequences for console, halt, fault, reset and cycle counter.
module tb_memory_responder;
    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] raddr = 32'h0;
    logic [31:0] waddr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] wmask = 32'h0;
    logic        we = 1'b0;
    logic        cready = 1'b0;
    logic [31:0] rdata;
    logic [31:0] hcode;
    logic [7:0]  cdata;
    logic        cvalid;
    logic        halt;
    logic        fault;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] wm;
        logic [31:0] ra;
        logic        en;
        logic [31:0] rd;
        logic        f;
    } vec_t;

    vec_t v[15];

    memory_responder #(.DEPTH_WORDS(4096), .MMIO_BASE(MB), .CONSOLE_DEPTH(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .read_memory_address  (raddr),
        .read_memory_data     (rdata),
        .write_memory_address (waddr),
        .write_memory_data    (wdata),
        .write_memory_mask    (wmask),
        .memory_write_enable  (we),
        .console_data         (cdata),
        .console_valid        (cvalid),
        .console_ready        (cready),
        .halt                 (halt),
        .halt_code            (hcode),
        .fault                (fault)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        we = 1'b1;
        waddr = a;
        wdata = d;
        wmask = m;
        tick();
        we = 1'b0;
    endtask

    initial begin
        v[0]  = '{1'b1, 32'h100,  32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h100,  1'b0, 32'h0,         1'b0};
        v[1]  = '{1'b1, 32'h100,  32'h0000_1234, 32'h0000_FFFF, 32'h100,  1'b1, 32'hDEAD_BEEF, 1'b0};
        v[2]  = '{1'b0, 32'h0,    32'h0,         32'h0,         32'h100,  1'b1, 32'hDEAD_1234, 1'b0};
        v[3]  = '{1'b1, 32'h104,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h100,  1'b1, 32'hDEAD_1234, 1'b0};
        v[4]  = '{1'b1, 32'h104,  32'hFFFF_FFFF, 32'h0,         32'h104,  1'b1, 32'hA5A5_A5A5, 1'b0};
        v[5]  = '{1'b0, 32'h0,    32'h0,         32'h0,         32'h104,  1'b1, 32'hA5A5_A5A5, 1'b0};
        v[6]  = '{1'b1, 32'h105,  32'h0F0F_0000, 32'hFFFF_0000, 32'h104,  1'b1, 32'hA5A5_A5A5, 1'b0};
        v[7]  = '{1'b0, 32'h0,    32'h0,         32'h0,         32'h107,  1'b1, 32'h0F0F_A5A5, 1'b0};
        v[8]  = '{1'b1, 32'h3FFC, 32'h1234_5678, 32'hFFFF_FFFF, 32'h104,  1'b1, 32'h0F0F_A5A5, 1'b0};
        v[9]  = '{1'b0, 32'h0,    32'h0,         32'h0,         32'h3FFC, 1'b1, 32'h1234_5678, 1'b0};
        v[10] = '{1'b1, 32'h200,  32'hCAFE_0000, 32'hFFFF_FFFF, 32'h3FFC, 1'b1, 32'h1234_5678, 1'b0};
        v[11] = '{1'b1, 32'h200,  32'h0000_0001, 32'hFFFF_FFFF, 32'h200,  1'b1, 32'hCAFE_0000, 1'b0};
        v[12] = '{1'b1, 32'h0,    32'h1111_1111, 32'hFFFF_FFFF, 32'h200,  1'b1, 32'h0000_0001, 1'b0};
        v[13] = '{1'b1, 32'h4000, 32'h2222_2222, 32'hFFFF_FFFF, 32'h0,    1'b1, 32'h1111_1111, 1'b1};
        v[14] = '{1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    1'b1, 32'h1111_1111, 1'b1};

        tick();
        chk("reset rdata", rdata, 32'h0);
        chk("reset fault", {31'h0, fault}, 32'h0);
        chk("reset halt", {31'h0, halt}, 32'h0);
        chk("reset halt_code", hcode, 32'h0);
        chk("reset cvalid", {31'h0, cvalid}, 32'h0);
        chk("reset cdata", {24'h0, cdata}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            we = v[i].we;
            waddr = v[i].wa;
            wdata = v[i].wd;
            wmask = v[i].wm;
            raddr = v[i].ra;
            tick();
            if (v[i].en)
                chk($sformatf("vec%0d rdata", i), rdata, v[i].rd);
            chk($sformatf("vec%0d fault", i), {31'h0, fault}, {31'h0, v[i].f});
        end
        we = 1'b0;

        reset = 1'b0;
        #1;
        chk("midreset rdata", rdata, 32'h0);
        chk("midreset fault", {31'h0, fault}, 32'h0);
        tick();
        reset = 1'b1;

`ifdef MEMORY_RESPONDER_MMIO_EN
        cready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(MB, 32'(8'h41 + i), 32'hFF);
            if (i == 0) begin
                chk("first push cvalid", {31'h0, cvalid}, 32'h1);
                chk("first push cdata", {24'h0, cdata}, 32'h41);
            end
        end
        raddr = MB + 32'h14;
        tick();
        chk("overflow after I", rdata, 32'h1);
        raddr = MB + 32'h4;
        tick();
        chk("status full", rdata, 32'h22);
        chk("mmio no fault", {31'h0, fault}, 32'h0);
        raddr = 32'h0;
        cready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d cvalid", i), {31'h0, cvalid}, 32'h1);
            chk($sformatf("drain%0d cdata", i), {24'h0, cdata}, 32'(8'h41 + i));
            tick();
        end
        chk("drained cvalid", {31'h0, cvalid}, 32'h0);
        cready = 1'b0;
        wr(MB, 32'h51, 32'hFFFF_FF00);
        chk("mask low zero no push", {31'h0, cvalid}, 32'h0);
        for (int i = 0; i < 8; i++)
            wr(MB, 32'(8'h61 + i), 32'hFF);
        cready = 1'b1;
        wr(MB, 32'h5A, 32'hFF);
        cready = 1'b0;
        chk("push+pop head", {24'h0, cdata}, 32'h62);
        raddr = MB + 32'h4;
        tick();
        chk("push+pop status", rdata, 32'h22);
        raddr = MB + 32'h14;
        tick();
        chk("push+pop overflow", rdata, 32'h1);
        raddr = MB + 32'h20;
        wr(MB + 32'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("unlisted rdata", rdata, 32'h0);
        chk("unlisted fault", {31'h0, fault}, 32'h0);
        raddr = 32'h0;
        wr(MB + 32'h10, 32'h2A, 32'hFFFF_FFFF);
        chk("halt set", {31'h0, halt}, 32'h1);
        chk("halt code", hcode, 32'h2A);
        wr(MB + 32'h10, 32'h55, 32'hFFFF_FFFF);
        chk("halt code sticky", hcode, 32'h2A);
        raddr = 32'h4000;
        tick();
        chk("unmapped rdata", rdata, 32'h0);
        chk("unmapped fault", {31'h0, fault}, 32'h1);
        raddr = 32'h0;
        cready = 1'b1;
        tick();
        chk("middrain cdata", {24'h0, cdata}, 32'h63);
        reset = 1'b0;
        #1;
        chk("rst cvalid", {31'h0, cvalid}, 32'h0);
        chk("rst cdata", {24'h0, cdata}, 32'h0);
        chk("rst halt", {31'h0, halt}, 32'h0);
        chk("rst halt_code", hcode, 32'h0);
        chk("rst fault", {31'h0, fault}, 32'h0);
        tick();
        reset = 1'b1;
        cready = 1'b0;
        for (int i = 0; i < 5; i++)
            tick();
        raddr = MB + 32'h8;
        tick();
        chk("cycle lo", rdata, 32'd5);
        raddr = MB + 32'hC;
        tick();
        chk("cycle hi", rdata, 32'd0);
        raddr = MB + 32'h8;
        tick();
        chk("cycle lo again", rdata, 32'd7);
        raddr = 32'h0;
`else
        raddr = MB + 32'h8;
        tick();
        chk("disabled mmio rdata", rdata, 32'h0);
        chk("disabled mmio fault", {31'h0, fault}, 32'h1);
        raddr = 32'h0;
        wr(MB + 32'h10, 32'h2A, 32'hFFFF_FFFF);
        chk("disabled halt", {31'h0, halt}, 32'h0);
        chk("disabled halt_code", hcode, 32'h0);
        cready = 1'b0;
        wr(MB, 32'h41, 32'hFF);
        chk("disabled cvalid", {31'h0, cvalid}, 32'h0);
        chk("disabled cdata", {24'h0, cdata}, 32'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("disabled reset fault", {31'h0, fault}, 32'h0);
`endif
        raddr = 32'h4000;
        tick();
        chk("depth boundary rdata", rdata, 32'h0);
        chk("depth boundary fault", {31'h0, fault}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
